silencer_v3: RTL and testbench

Parametrised, time-multiplexed silencer that slews each transducer's duty and phase toward its target value by a bounded step per update. Phase moves along the shortest path on the per-channel cycle circle; duty moves linearly. One sweep over all DEPTH channels runs per START pulse, normally once per ultrasound period from the time-count generator. Each sweep reads targets through a synchronous read port and streams smoothed values, one channel per cycle, to the PWM generators' register file. It replaces the fixed-step array silencer: it adds independent duty and phase steps, a bypass mode, and a handshake.

---
 rtl/silencer_v3.sv | 164 ++++++++++++++++
 tb/tb_silencer_v3.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/silencer_v3.sv
// Time-multiplexed duty/phase silencer: each START sweeps all DEPTH channels and
// moves every channel toward its target by at most one step, or bypasses to the clamped target.
module silencer_v3 #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic             START,
  input  logic [WIDTH-1:0] STEP_DUTY,
  input  logic [WIDTH-1:0] STEP_PHASE,
  output logic [AW-1:0]    TGT_ADDR,
  input  logic [WIDTH-1:0] TGT_CYCLE,
  input  logic [WIDTH-1:0] TGT_DUTY,
  input  logic [WIDTH-1:0] TGT_PHASE,
  output logic             OUT_VALID,
  output logic [AW-1:0]    OUT_ADDR,
  output logic [WIDTH-1:0] DUTY_S,
  output logic [WIDTH-1:0] PHASE_S,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           r_state, w_state_next;
  logic [AW-1:0]    r_addr;
  logic [1:0]       r_drain_cnt;
  logic             r_rd_valid;
  logic [AW-1:0]    r_rd_addr;
  logic [WIDTH-1:0] r_cur_duty  [DEPTH];
  logic [WIDTH-1:0] r_cur_phase [DEPTH];

  logic             w_done;
  logic [WIDTH-1:0] w_cur_duty, w_cur_phase;
  logic             w_c_zero;
  logic [WIDTH-1:0] w_c_m1, w_duty_t, w_phase_t;
  logic [WIDTH-1:0] w_duty_diff, w_duty_m, w_duty_slew;
  logic [WIDTH-1:0] w_ph_cur, w_ph_r, w_ph_back, w_ph_fwd_m, w_ph_back_m, w_ph_slew;
  logic [WIDTH:0]   w_ph_sum;
  logic [WIDTH-1:0] w_new_duty, w_new_phase;

  // ---------------------------------------------------------------- control FSM
  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE:  if (START) w_state_next = S_ISSUE;
      S_ISSUE: if (r_addr == LAST_ADDR) w_state_next = S_DRAIN;
      S_DRAIN: begin
        if (r_drain_cnt == 2'd2) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_addr      <= '0;
      r_drain_cnt <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      if (r_state == S_ISSUE) r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
      r_rd_valid  <= (r_state == S_ISSUE);
      r_rd_addr   <= r_addr;
    end
  end

  // ---------------------------------------------------------------- compute stage
  assign w_cur_duty  = r_cur_duty[r_rd_addr];
  assign w_cur_phase = r_cur_phase[r_rd_addr];

  always_comb begin
    w_c_zero  = (TGT_CYCLE == '0);
    w_c_m1    = TGT_CYCLE - WIDTH'(1);
    w_duty_t  = '0;
    w_phase_t = '0;
    if (!w_c_zero) begin
      w_duty_t  = (TGT_DUTY  > TGT_CYCLE) ? TGT_CYCLE : TGT_DUTY;
      w_phase_t = (TGT_PHASE > w_c_m1)    ? w_c_m1    : TGT_PHASE;
    end
  end

  always_comb begin
    w_duty_diff = (w_duty_t >= w_cur_duty) ? w_duty_t - w_cur_duty : w_cur_duty - w_duty_t;
    w_duty_m    = (w_duty_diff < STEP_DUTY) ? w_duty_diff : STEP_DUTY;
    w_duty_slew = (w_duty_t >= w_cur_duty) ? w_cur_duty + w_duty_m : w_cur_duty - w_duty_m;
  end

  // Distances are taken modulo C in WIDTH bits: every true result lies in [0, C),
  // so the modular wrap of the WIDTH-bit subtraction yields the exact value.
  always_comb begin
    w_ph_cur    = (w_cur_phase >= TGT_CYCLE) ? w_c_m1 : w_cur_phase;
    w_ph_r      = (w_phase_t >= w_ph_cur) ? w_phase_t - w_ph_cur
                                          : w_phase_t + TGT_CYCLE - w_ph_cur;
    w_ph_back   = TGT_CYCLE - w_ph_r;
    w_ph_fwd_m  = (w_ph_r    < STEP_PHASE) ? w_ph_r    : STEP_PHASE;
    w_ph_back_m = (w_ph_back < STEP_PHASE) ? w_ph_back : STEP_PHASE;
    w_ph_sum    = {1'b0, w_ph_cur} + {1'b0, w_ph_fwd_m};
    w_ph_slew   = w_ph_cur;
    if (w_c_zero) begin
      w_ph_slew = '0;
    end else if (w_ph_r == '0) begin
      w_ph_slew = w_ph_cur;
    end else if (w_ph_r <= w_ph_back) begin
      w_ph_slew = (w_ph_sum >= {1'b0, TGT_CYCLE}) ? WIDTH'(w_ph_sum - {1'b0, TGT_CYCLE})
                                                  : w_ph_sum[WIDTH-1:0];
    end else begin
      w_ph_slew = (w_ph_cur >= w_ph_back_m) ? w_ph_cur - w_ph_back_m
                                            : w_ph_cur + TGT_CYCLE - w_ph_back_m;
    end
  end

  assign w_new_duty  = ENABLE ? w_duty_slew : w_duty_t;
  assign w_new_phase = ENABLE ? w_ph_slew   : w_phase_t;

  // ---------------------------------------------------------------- state + outputs
  // NOTE: the per-channel state array is reset explicitly because a reset mid-sweep
  // must restart every channel from zero; this forces flops rather than a RAM macro.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cur_duty[i]  <= '0;
        r_cur_phase[i] <= '0;
      end
      OUT_VALID <= 1'b0;
      OUT_ADDR  <= '0;
      DUTY_S    <= '0;
      PHASE_S   <= '0;
    end else begin
      OUT_VALID <= r_rd_valid;
      if (r_rd_valid) begin
        r_cur_duty[r_rd_addr]  <= w_new_duty;
        r_cur_phase[r_rd_addr] <= w_new_phase;
        OUT_ADDR               <= r_rd_addr;
        DUTY_S                 <= w_new_duty;
        PHASE_S                <= w_new_phase;
      end
    end
  end

  assign TGT_ADDR = r_addr;
  assign BUSY     = (r_state != S_IDLE);
  assign DONE     = w_done;

endmodule

// File: tb/tb_silencer_v3.sv
// Scoreboard bench for silencer_v3 (DEPTH=4): a behavioural model predicts each
// sweep's outputs, which are popped and compared as OUT_VALID beats arrive.
module tb_silencer_v3;

  localparam int WIDTH = 13;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             start;
  logic [WIDTH-1:0] step_duty, step_phase;
  logic [AW-1:0]    tgt_addr;
  logic [WIDTH-1:0] tgt_cycle, tgt_duty, tgt_phase;
  logic             out_valid;
  logic [AW-1:0]    out_addr;
  logic [WIDTH-1:0] duty_s, phase_s;
  logic             busy, done;

  int total = 0;
  int bad   = 0;

  int mem_c [DEPTH];
  int mem_d [DEPTH];
  int mem_p [DEPTH];
  int m_duty  [DEPTH];
  int m_phase [DEPTH];
  int obs_duty  [DEPTH];
  int obs_phase [DEPTH];

  typedef struct {
    int addr;
    int duty;
    int phase;
  } exp_t;
  exp_t sb[$];

  silencer_v3 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .START(start),
    .STEP_DUTY(step_duty), .STEP_PHASE(step_phase), .TGT_ADDR(tgt_addr),
    .TGT_CYCLE(tgt_cycle), .TGT_DUTY(tgt_duty), .TGT_PHASE(tgt_phase),
    .OUT_VALID(out_valid), .OUT_ADDR(out_addr), .DUTY_S(duty_s), .PHASE_S(phase_s),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Synchronous target memory with one cycle of read latency.
  always @(posedge clk) begin
    tgt_cycle <= WIDTH'(mem_c[tgt_addr]);
    tgt_duty  <= WIDTH'(mem_d[tgt_addr]);
    tgt_phase <= WIDTH'(mem_p[tgt_addr]);
  end

  task automatic set_tgt(input int k, input int c, input int d, input int p);
    mem_c[k] = c;
    mem_d[k] = d;
    mem_p[k] = p;
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_duty[k]  = 0;
      m_phase[k] = 0;
    end
  endtask

  // Reference behaviour in plain integer arithmetic; pushes one expectation per channel.
  function automatic void model_sweep();
    int c, dt, pt, d, r, mag, en, sd, sp;
    exp_t e;
    en = int'(enable);
    sd = int'(step_duty);
    sp = int'(step_phase);
    for (int k = 0; k < DEPTH; k++) begin
      c  = mem_c[k];
      dt = (c == 0) ? 0 : ((mem_d[k] < c) ? mem_d[k] : c);
      pt = (c == 0) ? 0 : ((mem_p[k] < c - 1) ? mem_p[k] : c - 1);
      if (en == 0) begin
        m_duty[k]  = dt;
        m_phase[k] = pt;
      end else begin
        d = dt - m_duty[k];
        if (d > 0)      m_duty[k] += (d < sd) ? d : sd;
        else if (d < 0) m_duty[k] -= (-d < sd) ? -d : sd;
        if (c == 0) begin
          m_phase[k] = 0;
        end else begin
          if (m_phase[k] >= c) m_phase[k] = c - 1;
          r = (((pt - m_phase[k]) % c) + c) % c;
          if (r != 0) begin
            if (2 * r <= c) begin
              mag = (r < sp) ? r : sp;
              m_phase[k] += mag;
            end else begin
              mag = (c - r < sp) ? c - r : sp;
              m_phase[k] -= mag;
            end
            m_phase[k] = ((m_phase[k] % c) + c) % c;
          end
        end
      end
      e.addr  = k;
      e.duty  = m_duty[k];
      e.phase = m_phase[k];
      sb.push_back(e);
    end
  endfunction

  // One full sweep: predicts, pulses START (optionally again while busy) and
  // compares each output beat against the scoreboard.
  task automatic run_sweep(input bit repulse);
    int   cyc, n_out;
    bit   seen_done;
    exp_t e;
    model_sweep();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1; n_out = 0; seen_done = 1'b0;
    while (!seen_done && cyc < DEPTH + 20) begin
      if (repulse && cyc == 2) start = 1'b1;
      if (cyc == 3) start = 1'b0;
      if (out_valid) begin
        n_out++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sweep_extra_output: got addr=%0d, required no output", out_addr);
        end else begin
          e = sb.pop_front();
          if (int'(out_addr) !== e.addr || int'(duty_s) !== e.duty || int'(phase_s) !== e.phase) begin
            bad++;
            $display("FAIL sweep_data: got addr=%0d duty=%0d phase=%0d, required addr=%0d duty=%0d phase=%0d",
                     out_addr, duty_s, phase_s, e.addr, e.duty, e.phase);
          end
          obs_duty[int'(out_addr)]  = int'(duty_s);
          obs_phase[int'(out_addr)] = int'(phase_s);
        end
      end
      if (done) seen_done = 1'b1;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!seen_done) begin
      bad++;
      $display("FAIL sweep_done_timeout: no DONE within %0d cycles", DEPTH + 20);
    end
    total++;
    if (n_out !== DEPTH) begin
      bad++;
      $display("FAIL sweep_count: got %0d outputs, required %0d", n_out, DEPTH);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sweep_missing: %0d expected outputs never arrived", sb.size());
    end
    sb.delete();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL sweep_busy_after: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got valid/busy/done=%b, required 000", {out_valid, busy, done});
    end
    total++;
    if (duty_s !== '0 || phase_s !== '0) begin
      bad++;
      $display("FAIL reset_data: got duty=%0d phase=%0d, required 0 0", duty_s, phase_s);
    end
    total++;
    if (tgt_addr !== '0 || out_addr !== '0) begin
      bad++;
      $display("FAIL reset_addr: got tgt=%0d out=%0d, required 0 0", tgt_addr, out_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timing();
    bit exp_busy, exp_valid, exp_done;
    model_sweep();
    sb.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int cyc = 1; cyc <= DEPTH + 5; cyc++) begin
      exp_busy  = (cyc <= DEPTH + 3);
      exp_valid = (cyc >= 3) && (cyc <= DEPTH + 2);
      exp_done  = (cyc == DEPTH + 3);
      total++;
      if (busy !== exp_busy || out_valid !== exp_valid || done !== exp_done) begin
        bad++;
        $display("FAIL timing_flags cyc=%0d: got busy/valid/done=%b%b%b, required %b%b%b",
                 cyc, busy, out_valid, done, exp_busy, exp_valid, exp_done);
      end
      if (cyc <= DEPTH) begin
        total++;
        if (int'(tgt_addr) !== cyc - 1) begin
          bad++;
          $display("FAIL timing_tgt_addr cyc=%0d: got %0d, required %0d", cyc, tgt_addr, cyc - 1);
        end
      end
      if (exp_valid) begin
        total++;
        if (int'(out_addr) !== cyc - 3) begin
          bad++;
          $display("FAIL timing_out_addr cyc=%0d: got %0d, required %0d", cyc, out_addr, cyc - 3);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_duty_slew();
    enable = 1'b1; step_duty = 13'd100; step_phase = 13'd0;
    set_tgt(0, 5000, 2500, 0);
    set_tgt(1, 5000, 30, 1234);
    set_tgt(2, 5000, 6000, 0);
    set_tgt(3, 300, 150, 299);
    for (int s = 1; s <= 26; s++) begin
      run_sweep(1'b0);
      if (s == 1 || s == 25 || s == 26) begin
        total++;
        if (obs_duty[0] !== ((s == 1) ? 100 : 2500)) begin
          bad++;
          $display("FAIL duty_slew sweep=%0d: got %0d, required %0d",
                   s, obs_duty[0], (s == 1) ? 100 : 2500);
        end
      end
    end
  endtask

  task automatic test_phase_wrap();
    enable = 1'b0;
    for (int k = 0; k < DEPTH; k++) set_tgt(k, 5000, 1000, 100);
    run_sweep(1'b0);
    enable = 1'b1; step_duty = 13'd50; step_phase = 13'd150;
    for (int k = 0; k < DEPTH; k++) set_tgt(k, 5000, 1000, 4900);
    run_sweep(1'b0);
    total++;
    if (obs_phase[0] !== 4950) begin
      bad++;
      $display("FAIL phase_wrap_1: got %0d, required 4950", obs_phase[0]);
    end
    run_sweep(1'b0);
    total++;
    if (obs_phase[0] !== 4900) begin
      bad++;
      $display("FAIL phase_wrap_2: got %0d, required 4900", obs_phase[0]);
    end
  endtask

  task automatic test_phase_tie();
    enable = 1'b0;
    for (int k = 0; k < DEPTH; k++) set_tgt(k, 5000, 0, 0);
    run_sweep(1'b0);
    enable = 1'b1; step_phase = 13'd100;
    set_tgt(0, 5000, 0, 2500);
    set_tgt(1, 5000, 0, 2501);
    set_tgt(2, 5000, 0, 2499);
    set_tgt(3, 5000, 0, 4999);
    run_sweep(1'b0);
    total++;
    if (obs_phase[0] !== 100 || obs_phase[1] !== 4900) begin
      bad++;
      $display("FAIL phase_tie: got %0d %0d, required 100 4900", obs_phase[0], obs_phase[1]);
    end
  endtask

  task automatic test_bypass_clamp();
    enable = 1'b0;
    for (int k = 0; k < DEPTH; k++) set_tgt(k, 5000, 6000, 7000);
    run_sweep(1'b0);
    total++;
    if (obs_duty[0] !== 5000 || obs_phase[0] !== 4999) begin
      bad++;
      $display("FAIL bypass_clamp: got duty=%0d phase=%0d, required 5000 4999", obs_duty[0], obs_phase[0]);
    end
    set_tgt(0, 0, 6000, 7000);
    run_sweep(1'b0);
    total++;
    if (obs_duty[0] !== 0 || obs_phase[0] !== 0) begin
      bad++;
      $display("FAIL bypass_c_zero: got duty=%0d phase=%0d, required 0 0", obs_duty[0], obs_phase[0]);
    end
  endtask

  task automatic test_cycle_change();
    enable = 1'b1; step_duty = 13'd200; step_phase = 13'd200;
    for (int k = 0; k < DEPTH; k++) set_tgt(k, 300, 100, 10 + 40 * k);
    repeat (3) run_sweep(1'b0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      enable     = 1'($urandom_range(0, 3) != 0);
      step_duty  = WIDTH'($urandom_range(0, 600));
      step_phase = WIDTH'((s == 5) ? 0 : $urandom_range(0, 3000));
      for (int k = 0; k < DEPTH; k++)
        set_tgt(k, (k == 3 && s == 2) ? 0 : $urandom_range(1, 8191),
                $urandom_range(0, 8191), $urandom_range(0, 8191));
      run_sweep(1'b0);
    end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1; step_duty = 13'd7; step_phase = 13'd9;
    for (int k = 0; k < DEPTH; k++) set_tgt(k, 1000, 500, 700);
    run_sweep(1'b1);
    run_sweep(1'b0);
  endtask

  task automatic test_reset_mid();
    bit hit;
    enable = 1'b1; step_duty = 13'd300; step_phase = 13'd40;
    for (int k = 0; k < DEPTH; k++) set_tgt(k, 5000, 2000, 3000);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < DEPTH + 20 && !hit; i++) begin
      if (out_valid && out_addr == AW'(2)) hit = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reset_mid_wait: output 2 not seen within %0d cycles", DEPTH + 20);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || duty_s !== '0) begin
      bad++;
      $display("FAIL reset_mid_abort: got valid=%0b busy=%0b duty=%0d, required 0 0 0",
               out_valid, busy, duty_s);
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_sweep(1'b0);
    total++;
    if (obs_duty[3] !== 300 || obs_phase[3] !== 4960) begin
      bad++;
      $display("FAIL reset_mid_restart: got duty=%0d phase=%0d, required 300 4960",
               obs_duty[3], obs_phase[3]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; enable = 1'b1;
    step_duty = '0; step_phase = '0;
    for (int k = 0; k < DEPTH; k++) begin
      set_tgt(k, 0, 0, 0);
      obs_duty[k]  = -1;
      obs_phase[k] = -1;
    end
    model_reset();
    test_reset();
    test_timing();
    test_duty_slew();
    test_phase_wrap();
    test_phase_tie();
    test_bypass_clamp();
    test_cycle_change();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
